// File: rtl/eth_rx_mac_filter.sv
// eth_rx_mac_filter: destination-MAC filter for the 64-bit RX AXI-Stream.
// Forwards frames for this station, discards the rest and runts, and keeps saturating statistics.
module eth_rx_mac_filter #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic [47:0]              cfg_mac_addr,
    input  logic                     cfg_promisc,
    input  logic                     cfg_bcast_en,
    input  logic                     cfg_mcast_en,
    output logic [COUNTER_WIDTH-1:0] stat_pass_frames,
    output logic [COUNTER_WIDTH-1:0] stat_drop_frames,
    output logic [COUNTER_WIDTH-1:0] stat_runt_frames,
    output logic [COUNTER_WIDTH-1:0] stat_bad_frames
);
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic [COUNTER_WIDTH-1:0] pass_q, pass_d, drop_q, drop_d, runt_q, runt_d, bad_q, bad_d;
    logic [47:0]             da;
    logic                    accept, first, runt, match, load;
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c, input logic inc);
        return c + COUNTER_WIDTH'(inc && !(&c));
    endfunction
    always_comb begin
        da            = {s_axis_tdata[7:0], s_axis_tdata[15:8], s_axis_tdata[23:16],
                         s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
        s_axis_tready = rst_n && (state_q == DROP || !tvalid_q || m_axis_tready);
        accept        = s_axis_tvalid && s_axis_tready;
        first         = accept && state_q == IDLE;
        runt          = s_axis_tlast && s_axis_tkeep[5:0] != 6'h3F;
        match         = cfg_promisc || da == cfg_mac_addr || (cfg_bcast_en && &da) ||
                        (cfg_mcast_en && da[40] && !(&da));
        load          = accept && (state_q == PASS || (state_q == IDLE && !runt && match));
        // A runt always carries tlast, so it can never leave IDLE.
        state_d       = !accept ? state_q : s_axis_tlast ? IDLE :
                        state_q == IDLE ? (match ? PASS : DROP) : state_q;
        tvalid_d      = load || (tvalid_q && !m_axis_tready);
        tdata_d       = load ? s_axis_tdata : tdata_q;
        tkeep_d       = load ? s_axis_tkeep : tkeep_q;
        tlast_d       = load ? s_axis_tlast : tlast_q;
        tuser_d       = load ? s_axis_tuser : tuser_q;
        pass_d        = sat_inc(pass_q, load && s_axis_tlast);
        bad_d         = sat_inc(bad_q, load && s_axis_tlast && s_axis_tuser);
        drop_d        = sat_inc(drop_q, first && (runt || !match));
        runt_d        = sat_inc(runt_q, first && runt);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            pass_q   <= '0;
            drop_q   <= '0;
            runt_q   <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            pass_q   <= pass_d;
            drop_q   <= drop_d;
            runt_q   <= runt_d;
            bad_q    <= bad_d;
        end
    end
    assign m_axis_tdata     = tdata_q;
    assign m_axis_tkeep     = tkeep_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tuser     = tuser_q;
    assign stat_pass_frames = pass_q;
    assign stat_drop_frames = drop_q;
    assign stat_runt_frames = runt_q;
    assign stat_bad_frames  = bad_q;
endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// tb_eth_rx_mac_filter: scoreboard bench for the RX destination-MAC filter.
module tb_eth_rx_mac_filter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic [47:0] cfg_mac_addr = 48'h020000000001;
    logic        cfg_promisc = 1'b0, cfg_bcast_en = 1'b0, cfg_mcast_en = 1'b0;
    wire         s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    wire  [63:0] m_axis_tdata;
    wire  [7:0]  m_axis_tkeep;
    wire  [31:0] stat_pass_frames, stat_drop_frames, stat_runt_frames, stat_bad_frames;
    wire         sat_s_tready, sat_m_tvalid, sat_m_tlast, sat_m_tuser;
    wire  [63:0] sat_m_tdata;
    wire  [7:0]  sat_m_tkeep;
    wire  [1:0]  sat_pass, sat_drop, sat_runt, sat_bad;

    eth_rx_mac_filter u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
        .cfg_mcast_en(cfg_mcast_en),
        .stat_pass_frames(stat_pass_frames), .stat_drop_frames(stat_drop_frames),
        .stat_runt_frames(stat_runt_frames), .stat_bad_frames(stat_bad_frames)
    );

    eth_rx_mac_filter #(.COUNTER_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(sat_s_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(sat_m_tdata), .m_axis_tkeep(sat_m_tkeep), .m_axis_tvalid(sat_m_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(sat_m_tlast), .m_axis_tuser(sat_m_tuser),
        .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
        .cfg_mcast_en(cfg_mcast_en),
        .stat_pass_frames(sat_pass), .stat_drop_frames(sat_drop),
        .stat_runt_frames(sat_runt), .stat_bad_frames(sat_bad)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    int          checks = 0, errors = 0;
    beat_t       sb[$];
    beat_t       exp_b;
    logic        bp_mode = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;
    int          cyc = 0;
    logic [63:0] held_d = '0;
    logic        held_v = 1'b0;

    // Output backpressure pattern 1,0,0,1 when enabled, otherwise always ready.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        m_axis_tready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    end

    // Monitor: values are stable at negedge; a handshake completes at the following posedge.
    always @(negedge clk) begin
        if (held_v && m_axis_tvalid) begin
            checks++;
            if (m_axis_tdata !== held_d) begin
                errors++;
                $display("FAIL stall_hold got %h expected %h", m_axis_tdata, held_d);
            end
        end
        held_v = m_axis_tvalid && !m_axis_tready;
        held_d = m_axis_tdata;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got %h expected none", m_axis_tdata);
            end else begin
                exp_b = sb.pop_front();
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== exp_b) begin
                    errors++;
                    $display("FAIL out_beat got %h/%h/%b/%b expected %h/%h/%b/%b", m_axis_tdata,
                             m_axis_tkeep, m_axis_tlast, m_axis_tuser, exp_b.d, exp_b.k, exp_b.l, exp_b.u);
                end
            end
        end
    end

    task automatic drive_beat(input beat_t b, output int waits);
        bit acc = 0;
        waits = 0;
        s_axis_tdata = b.d;
        s_axis_tkeep = b.k;
        s_axis_tlast = b.l;
        s_axis_tuser = b.u;
        s_axis_tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout got no ready expected ready within 200 cycles");
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $fatal(1);
                end
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [47:0] da, input logic [7:0] lkeep,
                              input logic luser, input bit exp_pass, input bit chg_cfg);
        beat_t f[];
        int    w;
        f = new[n];
        for (int i = 0; i < n; i++) begin
            f[i].d = {$urandom, $urandom};
            f[i].k = 8'hFF;
            f[i].l = 1'b0;
            f[i].u = 1'b0;
        end
        f[0].d[47:0] = {da[7:0], da[15:8], da[23:16], da[31:24], da[39:32], da[47:40]};
        f[n-1].k = lkeep;
        f[n-1].l = 1'b1;
        f[n-1].u = luser;
        if (exp_pass) foreach (f[i]) sb.push_back(f[i]);
        for (int i = 0; i < n; i++) begin
            if (chg_cfg && i == 2) cfg_mac_addr = 48'h0A0B0C0D0E0F;
            drive_beat(f[i], w);
            if (!exp_pass && i > 0) begin
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL drop_ready got %0d stall cycles expected 0", w);
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        bp_mode = 1'b0;
        cfg_mac_addr = 48'h020000000001;
        cfg_promisc = 1'b0;
        cfg_bcast_en = 1'b0;
        cfg_mcast_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready got %b expected 0", s_axis_tready);
        end
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== '0) begin
            errors++;
            $display("FAIL reset_out got %b/%h expected 0/0", m_axis_tvalid, m_axis_tdata);
        end
        checks++;
        if ({stat_pass_frames, stat_drop_frames, stat_runt_frames, stat_bad_frames} !== '0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d/%0d/%0d expected 0/0/0/0", stat_pass_frames,
                     stat_drop_frames, stat_runt_frames, stat_bad_frames);
        end
        do_reset();
    endtask

    task automatic test_unicast();
        do_reset();
        send_frame(8, 48'h020000000001, 8'hFF, 1'b0, 1'b1, 1'b0);
        checks++;
        if (sb.size() != 1 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
            errors++;
            $display("FAIL unicast_latency got pending=%0d valid=%b last=%b expected 1/1/1",
                     sb.size(), m_axis_tvalid, m_axis_tlast);
        end
        drain();
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd1 || stat_drop_frames !== 32'd0) begin
            errors++;
            $display("FAIL unicast_count got pending=%0d pass=%0d drop=%0d expected 0/1/0",
                     sb.size(), stat_pass_frames, stat_drop_frames);
        end
    endtask

    task automatic test_filtering();
        do_reset();
        cfg_bcast_en = 1'b1;
        send_frame(4, 48'hFFFFFFFFFFFF, 8'h3F, 1'b0, 1'b1, 1'b0);
        send_frame(5, 48'h01005E000001, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(3, 48'h020000000002, 8'h07, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd1 || stat_drop_frames !== 32'd2) begin
            errors++;
            $display("FAIL filter_count got pending=%0d pass=%0d drop=%0d expected 0/1/2",
                     sb.size(), stat_pass_frames, stat_drop_frames);
        end
        cfg_mcast_en = 1'b1;
        send_frame(2, 48'h01005E000001, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain();
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd2) begin
            errors++;
            $display("FAIL mcast_count got pending=%0d pass=%0d expected 0/2", sb.size(), stat_pass_frames);
        end
    endtask

    task automatic test_runt_promisc();
        do_reset();
        cfg_promisc = 1'b1;
        send_frame(1, 48'h123456789ABC, 8'h1F, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (stat_drop_frames !== 32'd1 || stat_runt_frames !== 32'd1 || stat_pass_frames !== 32'd0) begin
            errors++;
            $display("FAIL runt_count got drop=%0d runt=%0d pass=%0d expected 1/1/0",
                     stat_drop_frames, stat_runt_frames, stat_pass_frames);
        end
        send_frame(1, 48'h123456789ABC, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain();
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd1 || stat_runt_frames !== 32'd1) begin
            errors++;
            $display("FAIL promisc_count got pending=%0d pass=%0d runt=%0d expected 0/1/1",
                     sb.size(), stat_pass_frames, stat_runt_frames);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bp_mode = 1'b1;
        send_frame(4, 48'h020000000001, 8'hFF, 1'b0, 1'b1, 1'b0);
        send_frame(1, 48'h020000000001, 8'hFF, 1'b0, 1'b1, 1'b0);
        send_frame(5, 48'h020000000001, 8'h7F, 1'b0, 1'b1, 1'b0);
        drain();
        bp_mode = 1'b0;
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd3 || stat_drop_frames !== 32'd0) begin
            errors++;
            $display("FAIL b2b_count got pending=%0d pass=%0d drop=%0d expected 0/3/0",
                     sb.size(), stat_pass_frames, stat_drop_frames);
        end
    endtask

    task automatic test_bad_cfg_change();
        do_reset();
        send_frame(6, 48'h020000000001, 8'h0F, 1'b1, 1'b1, 1'b1);
        drain();
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd1 || stat_bad_frames !== 32'd1) begin
            errors++;
            $display("FAIL bad_count got pending=%0d pass=%0d bad=%0d expected 0/1/1",
                     sb.size(), stat_pass_frames, stat_bad_frames);
        end
    endtask

    task automatic test_reset_midframe();
        beat_t b[3];
        int    w;
        do_reset();
        send_frame(2, 48'h0200000000AA, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stat_drop_frames !== 32'd1) begin
            errors++;
            $display("FAIL pre_reset_drop got %0d expected 1", stat_drop_frames);
        end
        for (int i = 0; i < 3; i++) b[i] = '{d: {$urandom, $urandom}, k: 8'hFF, l: 1'b0, u: 1'b0};
        b[0].d[47:0] = 48'h010000000002;
        sb.push_back(b[0]);
        sb.push_back(b[1]);
        for (int i = 0; i < 3; i++) drive_beat(b[i], w);
        s_axis_tvalid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || stat_drop_frames !== 32'd0 || stat_pass_frames !== 32'd0) begin
            errors++;
            $display("FAIL midreset_flush got valid=%b drop=%0d pass=%0d expected 0/0/0",
                     m_axis_tvalid, stat_drop_frames, stat_pass_frames);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midreset_beats got pending=%0d expected 0", sb.size());
        end
        @(posedge clk);
        #1;
        send_frame(3, 48'h020000000001, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain();
        checks++;
        if (sb.size() != 0 || stat_pass_frames !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_frame got pending=%0d pass=%0d expected 0/1", sb.size(), stat_pass_frames);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) send_frame(2, 48'h0200000000BB, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (sat_drop !== 2'd3 || stat_drop_frames !== 32'd5) begin
            errors++;
            $display("FAIL saturation got narrow=%0d wide=%0d expected 3/5", sat_drop, stat_drop_frames);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_filtering();
        test_runt_promisc();
        test_back_to_back();
        test_bad_cfg_change();
        test_reset_midframe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
